rpn_eval: RTL

RPN_EVAL -- requirements
Module: rpn_eval

---
 rtl/rpn_pkg.sv | 41 ++++
 rtl/rpn_eval_operand_stack.sv | 73 +++++++
 rtl/rpn_eval.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/rpn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rpn_pkg
// Description : Shared encodings for the RPN expression evaluator: token
//               kinds, operator selects, status codes and FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package rpn_pkg;

    // Token kinds carried on tok_kind
    localparam logic [1:0] KIND_OPERAND  = 2'b00;
    localparam logic [1:0] KIND_OPERATOR = 2'b01;
    localparam logic [1:0] KIND_END      = 2'b10;
    localparam logic [1:0] KIND_RSVD     = 2'b11;  // behaves as END

    // Operator selects carried on tok_data[1:0]
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    // Completion status codes
    localparam logic [1:0] ERR_OK        = 2'b00;
    localparam logic [1:0] ERR_UNDERFLOW = 2'b01;
    localparam logic [1:0] ERR_OVERFLOW  = 2'b10;
    localparam logic [1:0] ERR_MALFORMED = 2'b11;

    // Evaluator control states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POP_B  = 3'd1,
        POP_A  = 3'd2,
        CALC   = 3'd3,
        PUSH   = 3'd4,
        FINAL  = 3'd5,
        DRAIN  = 3'd6,
        REPORT = 3'd7
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rpn_eval_operand_stack.sv
`default_nettype none
// ============================================================================
// Module      : operand_stack
// Description : LIFO operand store with registered read port. A pop makes
//               the top entry visible on data_out in the following cycle.
//               clr beats push and pop; push when full and pop when empty
//               are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_stack #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clr,
    input  logic [WIDTH-1:0]         data_in,
    output logic [WIDTH-1:0]         data_out,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_data_out;

    logic [AW-1:0]    w_wr_idx;
    logic [AW-1:0]    w_rd_idx;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign data_out  = r_data_out;

    // Next free slot sits at count, current top at count-1
    assign w_wr_idx  = r_count[AW-1:0];
    assign w_rd_idx  = AW'(r_count - CW'(1));
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty && !w_do_push;

    // Storage, depth counter and registered read-out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_count    <= '0;
            r_data_out <= '0;
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_count    <= '0;
            r_data_out <= '0;
        end else if (w_do_push) begin
            r_mem[w_wr_idx] <= data_in;
            r_count         <= r_count + CW'(1);
        end else if (w_do_pop) begin
            r_data_out <= r_mem[w_rd_idx];
            r_count    <= r_count - CW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/rpn_eval.sv
`default_nettype none
// ============================================================================
// Module      : rpn_eval
// Description : Reverse-Polish expression evaluator. Consumes a token
//               stream of operands, operators and an end marker, and
//               reports the final value with a status code on a one-cycle
//               done pulse. After any error the rest of the expression is
//               drained up to its end marker.
// Revision    : 1.0 - initial release
// ============================================================================
module rpn_eval
    import rpn_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tok_valid,
    input  logic [1:0]       tok_kind,
    input  logic [WIDTH-1:0] tok_data,
    output logic             tok_ready,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic [1:0]       err_code
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_r;
    logic [1:0]       r_op;
    logic [1:0]       r_err;        // error latched while draining
    logic [WIDTH-1:0] r_result;
    logic [1:0]       r_err_code;
    logic             r_done;

    logic             w_accept;
    logic             w_is_end;
    logic             w_push;
    logic             w_pop;
    logic             w_clr;
    logic [WIDTH-1:0] w_stk_in;
    logic [WIDTH-1:0] w_stk_out;
    logic             w_full;
    logic             w_empty;
    logic [CW-1:0]    w_count;

    // Wrapping arithmetic: every result is truncated to WIDTH bits
    function automatic logic [WIDTH-1:0] f_calc(
        input logic [1:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] v;
        case (op)
            OP_ADD:  v = a + b;
            OP_SUB:  v = a - b;
            OP_MUL:  v = a * b;
            default: v = a ^ b;
        endcase
        return v;
    endfunction

    assign tok_ready = (r_state == IDLE) || (r_state == DRAIN);
    assign w_accept  = tok_valid && tok_ready;
    assign w_is_end  = tok_kind[1];   // 10 and reserved 11 both terminate
    assign w_stk_in  = (r_state == PUSH) ? r_r : tok_data;
    assign w_clr     = (r_state == REPORT);

    assign result    = r_result;
    assign err_code  = r_err_code;
    assign done      = r_done;

    // Stack strobes decoded from the current state and accepted token
    always_comb begin
        w_push = 1'b0;
        w_pop  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    case (tok_kind)
                        KIND_OPERAND:  w_push = !w_full;
                        KIND_OPERATOR: w_pop  = (w_count >= CW'(2));
                        default:       w_pop  = (w_count == CW'(1));
                    endcase
                end
            end
            POP_B:   w_pop  = 1'b1;
            PUSH:    w_push = 1'b1;
            default: ;
        endcase
    end

    operand_stack #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_stack (
        .clk      (clk),
        .rst      (rst),
        .push     (w_push),
        .pop      (w_pop),
        .clr      (w_clr),
        .data_in  (w_stk_in),
        .data_out (w_stk_out),
        .full     (w_full),
        .empty    (w_empty),
        .count    (w_count)
    );

    // Evaluator FSM with registered result/status/done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_r        <= '0;
            r_op       <= '0;
            r_err      <= ERR_OK;
            r_result   <= '0;
            r_err_code <= ERR_OK;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        case (tok_kind)
                            KIND_OPERAND: begin
                                if (w_full) begin
                                    r_err   <= ERR_OVERFLOW;
                                    r_state <= DRAIN;
                                end
                            end
                            KIND_OPERATOR: begin
                                if (w_count < CW'(2)) begin
                                    r_err   <= ERR_UNDERFLOW;
                                    r_state <= DRAIN;
                                end else begin
                                    r_op    <= tok_data[1:0];
                                    r_state <= POP_B;
                                end
                            end
                            default: begin
                                if (w_count == CW'(1)) begin
                                    r_state <= FINAL;
                                end else begin
                                    r_result   <= '0;
                                    r_err_code <= ERR_MALFORMED;
                                    r_done     <= 1'b1;
                                    r_state    <= REPORT;
                                end
                            end
                        endcase
                    end
                end
                POP_B: begin
                    r_b     <= w_stk_out;
                    r_state <= POP_A;
                end
                POP_A: begin
                    r_a     <= w_stk_out;
                    r_state <= CALC;
                end
                CALC: begin
                    r_r     <= f_calc(r_op, r_a, r_b);
                    r_state <= PUSH;
                end
                PUSH: begin
                    r_state <= IDLE;
                end
                FINAL: begin
                    r_result   <= w_stk_out;
                    r_err_code <= ERR_OK;
                    r_done     <= 1'b1;
                    r_state    <= REPORT;
                end
                DRAIN: begin
                    if (w_accept && w_is_end) begin
                        r_result   <= '0;
                        r_err_code <= r_err;
                        r_done     <= 1'b1;
                        r_state    <= REPORT;
                    end
                end
                REPORT: begin
                    r_err   <= ERR_OK;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
